// File: rtl/buzzer_pkg.sv
// Shared types and field-layout helpers for the buzzer tone sequencer.
package buzzer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPlay,
    StGap
  } state_e;

  // Command word layout: {rest, half_period, duration}
  function automatic int unsigned rest_bit(int unsigned div_w, int unsigned dur_w);
    return div_w + dur_w;
  endfunction

  function automatic int unsigned half_lsb(int unsigned dur_w);
    return dur_w;
  endfunction

  function automatic int unsigned dur_lsb();
    return 0;
  endfunction

  function automatic int unsigned count_w(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/buzzer_tone_sequencer_if.sv
// Command-producer to sequencer bundle: FIFO write side, abort and status/pin outputs.
interface buzzer_tone_sequencer_if
  import buzzer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DUR_W      = 8
);

  localparam int unsigned CMD_W = 1 + DIV_W + DUR_W;
  localparam int unsigned CNT_W = count_w(FIFO_DEPTH);

  logic             Write_Req_Sig;
  logic [CMD_W-1:0] FIFO_Write_Data;
  logic             Abort_Sig;
  logic             Full_Sig;
  logic             Empty_Sig;
  logic [CNT_W-1:0] Count;
  logic             Busy_Sig;
  logic             Done_Pulse;
  logic             Overflow_Sig;
  logic             Pin_Out;

  modport master (
    output Write_Req_Sig, FIFO_Write_Data, Abort_Sig,
    input  Full_Sig, Empty_Sig, Count, Busy_Sig, Done_Pulse, Overflow_Sig, Pin_Out
  );

  modport slave (
    input  Write_Req_Sig, FIFO_Write_Data, Abort_Sig,
    output Full_Sig, Empty_Sig, Count, Busy_Sig, Done_Pulse, Overflow_Sig, Pin_Out
  );

endinterface

// File: rtl/buzzer_cmd_fifo.sv
// Synchronous command FIFO with registered read data, occupancy count and flush.
module buzzer_cmd_fifo
  import buzzer_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 25,
  localparam int unsigned CNT_W = count_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush_i,
  input  logic             wr_req_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_strobe_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_wr, do_rd;

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;
  assign rd_data_o    = rd_data_q;
  assign do_wr        = wr_req_i && !full_o && !flush_i;
  assign do_rd        = rd_en_i && !empty_o && !flush_i;
  assign ovf_strobe_o = wr_req_i && full_o && !flush_i;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) begin
        rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/buzzer_tone_sequencer.sv
// Plays queued tone/DC/rest commands on one buzzer pin, each followed by a silent gap.
module buzzer_tone_sequencer
  import buzzer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DUR_W       = 8,
  parameter int unsigned UNIT_CYCLES = 50000,
  parameter int unsigned GAP_UNITS   = 10
) (
  input logic CLK,
  input logic RST,
  buzzer_tone_sequencer_if.slave bus
);

  localparam int unsigned CMD_W    = 1 + DIV_W + DUR_W;
  localparam int unsigned CNT_W    = count_w(FIFO_DEPTH);
  localparam int unsigned REST_BIT = rest_bit(DIV_W, DUR_W);
  localparam int unsigned HALF_LSB = half_lsb(DUR_W);
  localparam int unsigned DUR_LSB  = dur_lsb();
  localparam int unsigned UNIT_W   = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int unsigned GAP_W    = (GAP_UNITS > 0) ? $clog2(GAP_UNITS + 1) : 1;
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_UNITS);

  logic             rd_en, fifo_full, fifo_empty, ovf_strobe;
  logic [CMD_W-1:0] rd_data;
  logic [CNT_W-1:0] fifo_count;

  logic             cmd_rest;
  logic [DIV_W-1:0] cmd_half;
  logic [DUR_W-1:0] cmd_dur;

  state_e            state_q;
  logic              rest_q;
  logic [DIV_W-1:0]  half_q, half_cnt_q;
  logic [DUR_W-1:0]  dur_q;
  logic [UNIT_W-1:0] unit_q;
  logic [GAP_W-1:0]  gap_q;
  logic              pin_q, done_q, ovf_q;
  logic              unit_last;

  assign rd_en     = (state_q == StIdle) && !fifo_empty && !bus.Abort_Sig;
  assign cmd_rest  = rd_data[REST_BIT];
  assign cmd_half  = rd_data[HALF_LSB +: DIV_W];
  assign cmd_dur   = rd_data[DUR_LSB +: DUR_W];
  assign unit_last = (unit_q == UNIT_LAST);

  buzzer_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .CLK          (CLK),
    .RST          (RST),
    .flush_i      (bus.Abort_Sig),
    .wr_req_i     (bus.Write_Req_Sig),
    .wr_data_i    (bus.FIFO_Write_Data),
    .rd_en_i      (rd_en),
    .rd_data_o    (rd_data),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .ovf_strobe_o (ovf_strobe)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      rest_q     <= 1'b0;
      half_q     <= '0;
      half_cnt_q <= '0;
      dur_q      <= '0;
      unit_q     <= '0;
      gap_q      <= '0;
      pin_q      <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ovf_strobe) ovf_q <= 1'b1;
      if (bus.Abort_Sig) begin
        state_q <= StIdle;
        pin_q   <= 1'b0;
        ovf_q   <= 1'b0;
        unit_q  <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (!fifo_empty) state_q <= StLoad;
          end
          StLoad: begin
            rest_q     <= cmd_rest;
            half_q     <= cmd_half;
            dur_q      <= cmd_dur;
            unit_q     <= '0;
            half_cnt_q <= '0;
            if (cmd_dur == '0) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end else begin
              state_q <= StPlay;
              pin_q   <= !cmd_rest;
            end
          end
          StPlay: begin
            unit_q <= unit_last ? '0 : unit_q + UNIT_W'(1);
            if (unit_last && dur_q == DUR_W'(1)) begin
              pin_q <= 1'b0;
              if (GAP_UNITS > 0) begin
                state_q <= StGap;
                gap_q   <= GAP_LOAD;
              end else begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end
            end else begin
              if (unit_last) dur_q <= dur_q - DUR_W'(1);
              // half=0 with rest=0 is a DC tone: the pin just stays high
              if (!rest_q && half_q != '0) begin
                if (half_cnt_q == half_q - DIV_W'(1)) begin
                  pin_q      <= !pin_q;
                  half_cnt_q <= '0;
                end else begin
                  half_cnt_q <= half_cnt_q + DIV_W'(1);
                end
              end
            end
          end
          StGap: begin
            unit_q <= unit_last ? '0 : unit_q + UNIT_W'(1);
            if (unit_last) begin
              if (gap_q == GAP_W'(1)) begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end else begin
                gap_q <= gap_q - GAP_W'(1);
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.Full_Sig     = fifo_full;
  assign bus.Empty_Sig    = fifo_empty;
  assign bus.Count        = fifo_count;
  assign bus.Busy_Sig     = (state_q != StIdle) || !fifo_empty;
  assign bus.Done_Pulse   = done_q;
  assign bus.Overflow_Sig = ovf_q;
  assign bus.Pin_Out      = pin_q;

endmodule

// File: doc/buzzer_tone_sequencer.md
Name: buzzer_tone_sequencer

Overview:
Parametrised successor to the fixed-pattern buzzer interface. It accepts tone commands through a write-request/full FIFO handshake and plays each command on a single buzzer pin. Each command is a square-wave tone, a DC-on tone or a rest, lasting a programmed number of time units, followed by a fixed inter-command gap. It sits between any command producer (demo FSM, UART decoder) and the board buzzer pin.

Parameters:
FIFO_DEPTH, 16, command FIFO entries; power of 2, minimum 2
DIV_W, 16, width of the tone half-period field, in clock cycles
DUR_W, 8, width of the duration field, in time units
UNIT_CYCLES, 50000, clock cycles per time unit (1 ms at 50 MHz); minimum 1
GAP_UNITS, 10, silent units after every played command; 0 disables the gap
CMD_W, 1+DIV_W+DUR_W, derived command width; not overridable

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
Write_Req_Sig  in  1  push FIFO_Write_Data when not full
FIFO_Write_Data  in  CMD_W  command word: [CMD_W-1] rest flag, [DIV_W+DUR_W-1:DUR_W] half-period, [DUR_W-1:0] duration
Abort_Sig  in  1  synchronous flush and stop
Full_Sig  out  1  FIFO full
Empty_Sig  out  1  FIFO empty
Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
Busy_Sig  out  1  state != IDLE or FIFO not empty
Done_Pulse  out  1  one-cycle pulse at command completion
Overflow_Sig  out  1  sticky flag: a write was dropped while full
Pin_Out  out  1  buzzer drive

Behaviour:
- Reset (async, RST=1): FIFO empty, Count=0, Full_Sig=0, Empty_Sig=1, Busy_Sig=0, Done_Pulse=0, Overflow_Sig=0, Pin_Out=0, state IDLE.
- FIFO: a write occurs when Write_Req_Sig=1 and Full_Sig=0. A write while full is dropped and sets Overflow_Sig. A simultaneous pop and write when not full both proceed. Full and Empty are derived from the registered Count, so a write in the same cycle as a pop at full is still rejected.
- FSM states: IDLE, LOAD, PLAY, GAP.
- IDLE: if not empty, pop (rd_en) and go to LOAD.
- LOAD: latch rest, half-period (half) and duration (dur). If dur=0, go to IDLE with Done_Pulse. Otherwise go to PLAY.
- PLAY: lasts exactly dur*UNIT_CYCLES cycles.
  - rest=1: Pin_Out=0.
  - rest=0, half=0: Pin_Out=1 constant.
  - rest=0, half>0: Pin_Out=1 on the first PLAY cycle, then toggles every half cycles. The half-period counter restarts at PLAY entry.
  - At the end, go to GAP if GAP_UNITS>0, else to IDLE.
- GAP: Pin_Out=0 for GAP_UNITS*UNIT_CYCLES cycles, then go to IDLE.
- Done_Pulse: registered, high for exactly the first IDLE cycle after completion.
- Latency: a write in cycle N to an empty idle block gives pop in N+1, LOAD in N+2, and the first PLAY cycle (Pin_Out=1) in N+3.
- Back-to-back commands: IDLE lasts exactly 1 cycle between commands when the FIFO is non-empty.
- Counters: the unit counter wraps at UNIT_CYCLES-1. The duration counter is DUR_W bits and counts down to 0. No counter may overflow for maximum field values.
- Pin_Out is registered and glitch-free. It is 0 in IDLE, LOAD and GAP.
- Abort_Sig=1 takes effect next cycle:
  - Count=0, state IDLE, Pin_Out=0.
  - Overflow_Sig is cleared.
  - Writes in the abort cycle are ignored.
  - No Done_Pulse is issued.
  - Abort overrides a simultaneous pop.
- Reset mid-operation: immediate return to reset values; no Done_Pulse.

Decomposition:
- Package buzzer_pkg holds:
  - state encoding (IDLE, LOAD, PLAY, GAP)
  - field offset functions: REST_BIT, HALF_LSB, DUR_LSB, derived from DIV_W and DUR_W
  - the Count width function
- Sub-module buzzer_cmd_fifo: parametrised synchronous FIFO (depth, width) with registered read data, Full/Empty/Count, flush input and an overflow strobe. The top level holds the FSM, the unit/duration/half-period counters and the Pin_Out register.

Test Plan:
Bench parameters: FIFO_DEPTH=4, DIV_W=8, DUR_W=4, UNIT_CYCLES=10, GAP_UNITS=2.
1. Reset: RST pulse mid-clock -> all outputs 0 immediately, Empty_Sig=1, Count=0.
2. Single tone: write {rest=0, half=3, dur=2} at cycle 0 -> Pin_Out 1,1,1,0,0,0,… from cycle 3 for 20 cycles, then 20 cycles of 0, then one Done_Pulse. Busy_Sig=1 throughout.
3. Overflow: 6 writes on consecutive cycles from idle -> first command popped at cycle 1, Count reaches 4, Full_Sig=1, 6th write dropped, Overflow_Sig=1. All 5 accepted commands play in order with 1-cycle IDLE spacing.
4. Modes: {rest=1, dur=3} -> Pin_Out=0 for 50 cycles, then Done_Pulse. {rest=0, half=0, dur=1} -> Pin_Out=1 for exactly 10 cycles.
5. Zero duration: {dur=0} -> Pin_Out stays 0, no gap, Done_Pulse 2 cycles after the pop.
6. Abort: Abort_Sig in the 5th PLAY cycle with 2 commands queued -> next cycle Pin_Out=0, Count=0, Empty_Sig=1, Overflow_Sig=0, no Done_Pulse. A subsequent write plays normally.
